// File: rtl/qos_packet_source.sv
// qos_packet_source: transmit-side traffic source for the 4-queue QoS buffer container.
// Emits 4-bit packets {queue_id[1:0], payload[1:0]} on in_number and announces each one
// by bumping the 12-bit received_yes counter. Packets come from a periodic automatic
// generator or from a one-cycle manual injection request; manual wins a tie.
//
// Ports:
//   clock, reset               rising-edge clock, asynchronous active-high reset
//   enable                     run the automatic interval timer while high
//   manual_valid/manual_packet one-cycle injection request, taken only in IDLE
//   manual_ready               one-cycle pulse on the edge a manual packet is emitted
//   in_number                  current packet, held until the next one
//   received_yes               packet strobe counter, +1 per packet, never wraps
//   sent_count1..sent_count4   saturating per-queue packet counts (queue 0..3)
//   busy, done                 EMIT/HOLD indicator, sticky "MAX_PACKETS sent" flag
//
// Build option: define QOS_PACKET_SOURCE_LFSR_EN to make the generator an 8-bit Galois
// LFSR (taps 0xB8, shift right); otherwise it is an 8-bit incrementing counter.
// All outputs are registered.

module qos_packet_source #(
  parameter int unsigned INTERVAL    = 1000,
  parameter int unsigned MIN_GAP     = 2,
  parameter logic [7:0]  SEED        = 8'hA5,
  parameter int unsigned MAX_PACKETS = 4095
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        manual_valid,
  input  logic [3:0]  manual_packet,
  output logic        manual_ready,
  output logic [3:0]  in_number,
  output logic [11:0] received_yes,
  output logic [11:0] sent_count1,
  output logic [11:0] sent_count2,
  output logic [11:0] sent_count3,
  output logic [11:0] sent_count4,
  output logic        busy,
  output logic        done
);

  // A misconfigured MAX_PACKETS is clamped so received_yes can never wrap.
  localparam int unsigned MAX_EFF       = (MAX_PACKETS > 4095) ? 4095 : MAX_PACKETS;
  localparam logic [11:0] MAX_CNT       = 12'(MAX_EFF);
  localparam logic [23:0] INTERVAL_LAST = 24'(INTERVAL - 1);
  // HOLD counts 0 .. MIN_GAP-2, i.e. MIN_GAP-1 cycles.
  localparam int unsigned HOLD_W        = (MIN_GAP > 2) ? $clog2(MIN_GAP - 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_GAP - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [23:0]       ivl_cnt_q, ivl_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]        gen_q, gen_d;
  logic              pend_q, pend_d;
  logic [3:0]        in_number_q, in_number_d;
  logic [11:0]       received_yes_q, received_yes_d;
  logic [3:0][11:0]  sent_cnt_q, sent_cnt_d;
  logic              manual_ready_q, manual_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic              auto_req;
  logic              launch;
  logic              launch_manual;
  logic [1:0]        qsel;
  logic [7:0]        gen_next;

  function automatic logic [11:0] sat_inc(input logic [11:0] v);
    return (v == 12'hFFF) ? v : v + 12'd1;
  endfunction

`ifdef QOS_PACKET_SOURCE_LFSR_EN
  assign gen_next = {1'b0, gen_q[7:1]} ^ (gen_q[0] ? 8'hB8 : 8'h00);
`else
  assign gen_next = gen_q + 8'd1;
`endif

  assign tick     = enable && (ivl_cnt_q == INTERVAL_LAST);
  // An automatic packet is due either now or from a tick that could not be served.
  assign auto_req = tick || pend_q;

  always_comb begin
    state_d        = state_q;
    ivl_cnt_d      = ivl_cnt_q;
    hold_cnt_d     = hold_cnt_q;
    gen_d          = gen_q;
    // A tick that is not served this cycle is remembered; only one can be pending.
    pend_d         = pend_q || tick;
    in_number_d    = in_number_q;
    received_yes_d = received_yes_q;
    sent_cnt_d     = sent_cnt_q;
    manual_ready_d = 1'b0;
    launch         = 1'b0;
    launch_manual  = 1'b0;
    qsel           = 2'd0;

    if (enable) begin
      ivl_cnt_d = tick ? 24'd0 : ivl_cnt_q + 24'd1;
    end

    case (state_q)
      ST_IDLE: begin
        if (manual_valid) begin
          launch        = 1'b1;
          launch_manual = 1'b1;
        end else if (auto_req) begin
          launch = 1'b1;
        end
      end
      ST_EMIT: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          if (received_yes_q >= MAX_CNT) begin
            state_d = ST_DONE;
          end else if (auto_req) begin
            // A deferred tick goes out as soon as the gap has elapsed, so a
            // manual/automatic collision yields strobes exactly MIN_GAP apart.
            launch = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        pend_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (launch) begin
      state_d = ST_EMIT;
      if (launch_manual) begin
        in_number_d = manual_packet;
      end else begin
        in_number_d = gen_q[3:0];
        gen_d       = gen_next;
        pend_d      = 1'b0;
      end
      qsel             = in_number_d[3:2];
      manual_ready_d   = launch_manual;
      received_yes_d   = sat_inc(received_yes_q);
      sent_cnt_d[qsel] = sat_inc(sent_cnt_q[qsel]);
    end

    busy_d = (state_d == ST_EMIT) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      ivl_cnt_q      <= '0;
      hold_cnt_q     <= '0;
      gen_q          <= SEED;
      pend_q         <= 1'b0;
      in_number_q    <= '0;
      received_yes_q <= '0;
      sent_cnt_q     <= '0;
      manual_ready_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      ivl_cnt_q      <= ivl_cnt_d;
      hold_cnt_q     <= hold_cnt_d;
      gen_q          <= gen_d;
      pend_q         <= pend_d;
      in_number_q    <= in_number_d;
      received_yes_q <= received_yes_d;
      sent_cnt_q     <= sent_cnt_d;
      manual_ready_q <= manual_ready_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign manual_ready = manual_ready_q;
  assign in_number    = in_number_q;
  assign received_yes = received_yes_q;
  assign sent_count1  = sent_cnt_q[0];
  assign sent_count2  = sent_cnt_q[1];
  assign sent_count3  = sent_cnt_q[2];
  assign sent_count4  = sent_cnt_q[3];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_qos_packet_source.sv
// Bench for qos_packet_source: directed stimulus pushes expected strobes into
// scoreboard queues; monitors pop and compare whenever received_yes steps.

module tb_qos_packet_source;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Main instance: INTERVAL=10, SEED=0, MIN_GAP=2, MAX_PACKETS=5
  logic        reset, enable, manual_valid;
  logic [3:0]  manual_packet;
  logic        manual_ready, busy, done;
  logic [3:0]  in_number;
  logic [11:0] received_yes, sc1, sc2, sc3, sc4;

  // Generator instance: INTERVAL=2, SEED=A5
  logic        reset_g, enable_g, manual_valid_g;
  logic [3:0]  manual_packet_g;
  logic        manual_ready_g, busy_g, done_g;
  logic [3:0]  in_number_g;
  logic [11:0] received_yes_g, sc1_g, sc2_g, sc3_g, sc4_g;

  qos_packet_source #(.INTERVAL(10), .MIN_GAP(2), .SEED(8'h00), .MAX_PACKETS(5)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .manual_valid(manual_valid), .manual_packet(manual_packet), .manual_ready(manual_ready),
    .in_number(in_number), .received_yes(received_yes),
    .sent_count1(sc1), .sent_count2(sc2), .sent_count3(sc3), .sent_count4(sc4),
    .busy(busy), .done(done)
  );

  qos_packet_source #(.INTERVAL(2), .MIN_GAP(2), .SEED(8'hA5), .MAX_PACKETS(4095)) dut_gen (
    .clock(clock), .reset(reset_g), .enable(enable_g),
    .manual_valid(manual_valid_g), .manual_packet(manual_packet_g), .manual_ready(manual_ready_g),
    .in_number(in_number_g), .received_yes(received_yes_g),
    .sent_count1(sc1_g), .sent_count2(sc2_g), .sent_count3(sc3_g), .sent_count4(sc4_g),
    .busy(busy_g), .done(done_g)
  );

  typedef struct {
    logic [3:0]  pkt;
    logic [11:0] ry;
    int          cyc;   // expected cycle after reset release, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  exp_t exp_g_q[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc;

  always @(posedge clock or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the main instance
  logic [11:0] prev_ry = '0;
  always begin
    exp_t e;
    @(posedge clock);
    #2;
    if (reset) begin
      prev_ry = '0;
    end else if (received_yes != prev_ry) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_strobe: got received_yes=%0d in_number=%0h, expected none", received_yes, in_number);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_pkt", 32'(in_number), 32'(e.pkt));
        chk("strobe_count", 32'(received_yes), 32'(e.ry));
        if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
        chk("count_sum", 32'(sc1) + 32'(sc2) + 32'(sc3) + 32'(sc4), 32'(received_yes));
      end
      prev_ry = received_yes;
    end
  end

  // Monitor for the generator instance
  logic [11:0] prev_ry_g = '0;
  always begin
    exp_t e;
    @(posedge clock);
    #2;
    if (reset_g) begin
      prev_ry_g = '0;
    end else if (received_yes_g != prev_ry_g) begin
      if (exp_g_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_gen_strobe: got received_yes=%0d in_number=%0h, expected none", received_yes_g, in_number_g);
      end else begin
        e = exp_g_q.pop_front();
        chk("gen_pkt", 32'(in_number_g), 32'(e.pkt));
        chk("gen_count", 32'(received_yes_g), 32'(e.ry));
        chk("gen_sum", 32'(sc1_g) + 32'(sc2_g) + 32'(sc3_g) + 32'(sc4_g), 32'(received_yes_g));
      end
      prev_ry_g = received_yes_g;
    end
  end

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (cyc < n) begin
      vectors++;
      errors++;
      $display("FAIL wait_cyc: got cycle %0d, expected %0d", cyc, n);
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_in_number"}, 32'(in_number), 0);
    chk({tag, "_received_yes"}, 32'(received_yes), 0);
    chk({tag, "_sent_sum"}, 32'(sc1) | 32'(sc2) | 32'(sc3) | 32'(sc4), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_manual_ready"}, 32'(manual_ready), 0);
  endtask

  task automatic push(input logic [3:0] p, input logic [11:0] r, input int c);
    exp_t e;
    e.pkt = p;
    e.ry  = r;
    e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_g(input logic [3:0] p, input logic [11:0] r);
    exp_t e;
    e.pkt = p;
    e.ry  = r;
    e.cyc = -1;
    exp_g_q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; enable = 1'b0; manual_valid = 1'b0; manual_packet = 4'h0;
    reset_g = 1'b0; enable_g = 1'b0; manual_valid_g = 1'b0; manual_packet_g = 4'h0;
    #2;
    reset = 1'b1;
    reset_g = 1'b1;
    repeat (2) @(negedge clock);
    reset_checks("reset");

    // Automatic packets every 10 cycles from SEED=0
    enable = 1'b1;
    push(4'h0, 12'd1, 10);
    push(4'h1, 12'd2, 20);
    push(4'h2, 12'd3, 30);
    reset = 1'b0;
    wait_cyc(35);
    enable = 1'b0;                      // interval counter freezes at 5
    chk("sent_count1_after_3", 32'(sc1), 3);
    chk("idle_busy", 32'(busy), 0);

    // Manual injection in IDLE
    wait_cyc(36);
    manual_valid = 1'b1;
    manual_packet = 4'b0111;
    push(4'h7, 12'd4, 37);
    @(negedge clock);
    manual_valid = 1'b0;
    chk("manual_ready_pulse", 32'(manual_ready), 1);
    chk("emit_busy", 32'(busy), 1);
    @(negedge clock);
    chk("manual_ready_drop", 32'(manual_ready), 0);
    chk("sent_count2_manual", 32'(sc2), 1);

    // Resume: counter continues from 5, tick at cycle 45 -> 5th packet -> DONE
    wait_cyc(40);
    enable = 1'b1;
    push(4'h3, 12'd5, 45);
    wait_cyc(46);
    chk("done_before_limit", 32'(done), 0);
    wait_cyc(47);
    chk("done_at_limit", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    wait_cyc(48);
    manual_valid = 1'b1;
    manual_packet = 4'b1101;
    @(negedge clock);
    manual_valid = 1'b0;
    chk("done_manual_ready", 32'(manual_ready), 0);
    wait_cyc(70);
    chk("done_received_yes", 32'(received_yes), 5);
    chk("done_sticky", 32'(done), 1);

    // Manual request colliding with an automatic tick
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset_checks("reset2");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    wait_cyc(9);
    manual_valid = 1'b1;
    manual_packet = 4'b0111;
    push(4'h7, 12'd1, 10);
    push(4'h0, 12'd2, 12);
    @(negedge clock);
    manual_valid = 1'b0;
    chk("collide_manual_ready", 32'(manual_ready), 1);
    chk("collide_sent_count2", 32'(sc2), 1);

    // Reset during HOLD after the third packet
    push(4'h1, 12'd3, 20);
    wait_cyc(21);
    chk("hold_busy", 32'(busy), 1);
    reset = 1'b1;
    #1;
    reset_checks("reset_hold");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    push(4'h0, 12'd1, 10);
    wait_cyc(12);
    enable = 1'b0;

    // Generator sequence check on the second instance
`ifdef QOS_PACKET_SOURCE_LFSR_EN
    push_g(4'h5, 12'd1);   // A5
    push_g(4'hA, 12'd2);   // EA
    push_g(4'h5, 12'd3);   // 75
    push_g(4'h2, 12'd4);   // 82
`else
    push_g(4'h5, 12'd1);   // A5
    push_g(4'h6, 12'd2);   // A6
    push_g(4'h7, 12'd3);   // A7
    push_g(4'h8, 12'd4);   // A8
`endif
    enable_g = 1'b1;
    @(negedge clock);
    reset_g = 1'b0;
    repeat (8) @(negedge clock);
    enable_g = 1'b0;
    repeat (6) @(negedge clock);
    chk("gen_received_yes", 32'(received_yes_g), 4);
    chk("gen_final_sum", 32'(sc1_g) + 32'(sc2_g) + 32'(sc3_g) + 32'(sc4_g), 32'(received_yes_g));

    chk("main_expected_left", exp_q.size(), 0);
    chk("gen_expected_left", exp_g_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
